// File: rtl/idecoder_pkg.sv
// Shared RV32I decode constants: base opcodes, one-hot class bit positions
// and the funct7 values that select the alternate ALU operation.
package idecoder_pkg;

  localparam logic [6:0] OP_LUI     = 7'h37;
  localparam logic [6:0] OP_AUIPC   = 7'h17;
  localparam logic [6:0] OP_JAL     = 7'h6F;
  localparam logic [6:0] OP_JALR    = 7'h67;
  localparam logic [6:0] OP_BRANCH  = 7'h63;
  localparam logic [6:0] OP_LOAD    = 7'h03;
  localparam logic [6:0] OP_STORE   = 7'h23;
  localparam logic [6:0] OP_INT_IMM = 7'h13;
  localparam logic [6:0] OP_INT_REG = 7'h33;
  localparam logic [6:0] OP_FENCE   = 7'h0F;
  localparam logic [6:0] OP_SYSTEM  = 7'h73;

  localparam int T_LUI      = 0;
  localparam int T_AUIPC    = 1;
  localparam int T_JAL      = 2;
  localparam int T_JALR     = 3;
  localparam int T_BRANCH   = 4;
  localparam int T_LOAD     = 5;
  localparam int T_STORE    = 6;
  localparam int T_INT_IMM  = 7;
  localparam int T_INT_REG  = 8;
  localparam int T_FENCE    = 9;
  localparam int T_SYSTEM   = 10;
  localparam int TYPE_WIDTH = 11;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

endpackage

// File: rtl/idecoder_comb.sv
// Combinational RV32I decoder: classifies one instruction word, extracts its
// register/immediate/funct fields and flags anything outside the base map.
module idecoder_comb
  import idecoder_pkg::*;
#(
  parameter int imm_width   = 32,
  parameter int reg_width   = 5,
  parameter int funct_width = 4,
  parameter int type_width  = TYPE_WIDTH
) (
  input  logic [31:0]            inst,
  output logic [6:0]             opcode,
  output logic [type_width-1:0]  cls,
  output logic [imm_width-1:0]   imm,
  output logic [reg_width-1:0]   rd,
  output logic [reg_width-1:0]   rs1,
  output logic [reg_width-1:0]   rs2,
  output logic [funct_width-1:0] funct,
  output logic                   illegal
);

  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [31:0]           imm_i, imm_s, imm_b, imm_u, imm_j, imm_raw;
  logic [type_width-1:0] cls_raw;
  logic                  use_rd, use_rs1, use_rs2, use_f3, alt, legal;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    cls_raw = '0;
    imm_raw = '0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_f3  = 1'b0;
    alt     = 1'b0;
    legal   = 1'b0;
    if (inst[1:0] == 2'b11) begin
      case (opcode)
        OP_LUI: begin
          cls_raw[T_LUI] = 1'b1; legal = 1'b1; use_rd = 1'b1; imm_raw = imm_u;
        end
        OP_AUIPC: begin
          cls_raw[T_AUIPC] = 1'b1; legal = 1'b1; use_rd = 1'b1; imm_raw = imm_u;
        end
        OP_JAL: begin
          cls_raw[T_JAL] = 1'b1; legal = 1'b1; use_rd = 1'b1; imm_raw = imm_j;
        end
        OP_JALR: begin
          cls_raw[T_JALR] = 1'b1; legal = 1'b1; imm_raw = imm_i;
          use_rd = 1'b1; use_rs1 = 1'b1; use_f3 = 1'b1;
        end
        OP_BRANCH: begin
          cls_raw[T_BRANCH] = 1'b1; legal = 1'b1; imm_raw = imm_b;
          use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1;
        end
        OP_LOAD: begin
          cls_raw[T_LOAD] = 1'b1; legal = 1'b1; imm_raw = imm_i;
          use_rd = 1'b1; use_rs1 = 1'b1; use_f3 = 1'b1;
        end
        OP_STORE: begin
          cls_raw[T_STORE] = 1'b1; legal = 1'b1; imm_raw = imm_s;
          use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1;
        end
        OP_INT_IMM: begin
          cls_raw[T_INT_IMM] = 1'b1; imm_raw = imm_i;
          use_rd = 1'b1; use_rs1 = 1'b1; use_f3 = 1'b1;
          // Shifts reuse the upper immediate bits as a funct7-like selector
          if (funct3 == 3'b001)      legal = (funct7 == F7_BASE);
          else if (funct3 == 3'b101) legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          else                       legal = 1'b1;
          alt = (funct3 == 3'b101) && inst[30];
        end
        OP_INT_REG: begin
          cls_raw[T_INT_REG] = 1'b1;
          use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1;
          legal = (funct7 == F7_BASE) ||
                  ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
          alt = (funct7 == F7_ALT);
        end
        OP_FENCE: begin
          cls_raw[T_FENCE] = 1'b1; legal = 1'b1; use_f3 = 1'b1;
        end
        OP_SYSTEM: begin
          cls_raw[T_SYSTEM] = 1'b1; legal = 1'b1; use_f3 = 1'b1;
        end
        default: legal = 1'b0;
      endcase
    end
  end

  // An unrecognised word still carries its opcode but no decoded content
  assign illegal = !legal;
  assign cls     = legal ? cls_raw : '0;
  assign imm     = legal ? imm_width'($signed(imm_raw)) : '0;
  assign rd      = (legal && use_rd)  ? reg_width'(inst[11:7])  : '0;
  assign rs1     = (legal && use_rs1) ? reg_width'(inst[19:15]) : '0;
  assign rs2     = (legal && use_rs2) ? reg_width'(inst[24:20]) : '0;
  assign funct   = legal ? funct_width'({alt, (use_f3 ? funct3 : 3'b000)}) : '0;

endmodule

// File: rtl/idecoder_stage.sv
// Registered decode stage between fetch and execute; a one-entry skid buffer
// keeps in_ready a pure flop output so no ready path runs back to fetch.
module idecoder_stage
  import idecoder_pkg::*;
#(
  parameter int inst_width  = 32,
  parameter int pc_width    = 32,
  parameter int imm_width   = 32,
  parameter int reg_width   = 5,
  parameter int funct_width = 4,
  parameter int type_width  = TYPE_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [inst_width-1:0]  in_inst,
  input  logic [pc_width-1:0]    in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [pc_width-1:0]    out_pc,
  output logic [6:0]             out_opcode,
  output logic [type_width-1:0]  out_type,
  output logic [imm_width-1:0]   out_imm,
  output logic [reg_width-1:0]   out_rd,
  output logic [reg_width-1:0]   out_rs1,
  output logic [reg_width-1:0]   out_rs2,
  output logic [funct_width-1:0] out_funct,
  output logic                   out_illegal
);

  localparam int bundle_width = pc_width + 7 + type_width + imm_width
                              + 3 * reg_width + funct_width + 1;

  logic [6:0]              dec_opcode;
  logic [type_width-1:0]   dec_type;
  logic [imm_width-1:0]    dec_imm;
  logic [reg_width-1:0]    dec_rd, dec_rs1, dec_rs2;
  logic [funct_width-1:0]  dec_funct;
  logic                    dec_illegal;

  logic [bundle_width-1:0] dec_bundle, out_bundle_reg, skid_bundle_reg;
  logic                    out_valid_reg, skid_full_reg;
  logic                    in_fire, out_open;

  idecoder_comb #(
    .imm_width   (imm_width),
    .reg_width   (reg_width),
    .funct_width (funct_width),
    .type_width  (type_width)
  ) u_comb (
    .inst    (in_inst),
    .opcode  (dec_opcode),
    .cls     (dec_type),
    .imm     (dec_imm),
    .rd      (dec_rd),
    .rs1     (dec_rs1),
    .rs2     (dec_rs2),
    .funct   (dec_funct),
    .illegal (dec_illegal)
  );

  assign dec_bundle = {in_pc, dec_opcode, dec_type, dec_imm,
                       dec_rd, dec_rs1, dec_rs2, dec_funct, dec_illegal};

  assign in_ready  = !skid_full_reg;
  assign in_fire   = in_valid && !skid_full_reg;
  assign out_open  = !out_valid_reg || out_ready;
  assign out_valid = out_valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg   <= 1'b0;
      skid_full_reg   <= 1'b0;
      out_bundle_reg  <= '0;
      skid_bundle_reg <= '0;
    end else if (out_open) begin
      // A full skid always drains first, so ordering is preserved
      if (skid_full_reg) begin
        out_bundle_reg <= skid_bundle_reg;
        out_valid_reg  <= 1'b1;
        skid_full_reg  <= 1'b0;
      end else if (in_fire) begin
        out_bundle_reg <= dec_bundle;
        out_valid_reg  <= 1'b1;
      end else begin
        out_valid_reg  <= 1'b0;
      end
    end else if (in_fire) begin
      skid_bundle_reg <= dec_bundle;
      skid_full_reg   <= 1'b1;
    end
  end

  assign {out_pc, out_opcode, out_type, out_imm,
          out_rd, out_rs1, out_rs2, out_funct, out_illegal} = out_bundle_reg;

endmodule
